// File: rtl/pll_pkg.sv
// pll_pkg
// Shared types and widths for the PLL configuration sequencer.
//   SEL_W           width of the output divider select
//   CODE_W          width of the PLL code
//   pll_seq_state_e sequencer states
package pll_pkg;

   localparam int SEL_W  = 3;
   localparam int CODE_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BYP_ENTER,
      ST_SETTLE,
      ST_WAIT_LOCK,
      ST_BYP_EXIT
   } pll_seq_state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync
// Two-flop synchroniser that brings the raw PLL lock into the reference clock domain.
//   clk_i    in   reference clock
//   rstn_i   in   asynchronous active-low reset, clears both flops to 0
//   async_i  in   raw asynchronous input
//   sync_o   out  synchronised output (two cycles of latency)
module pll_lock_sync (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic async_i,
   output logic sync_o
);

   logic [1:0] sync_ff;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_ff <= 2'b00;
      end else begin
         sync_ff <= {sync_ff[0], async_i};
      end
   end

   assign sync_o = sync_ff[1];

endmodule

// File: rtl/pll_cfg_sequencer.sv
// pll_cfg_sequencer
// Applies software-requested divider select / PLL code to the PLL in a safe order:
// enter bypass, apply the new values, wait for settle and a stable lock, release bypass.
//   clk_i           in   reference clock
//   rstn_i          in   asynchronous active-low reset
//   bypass_req_i    in   software bypass request
//   sel_req_i       in   requested divider select
//   code_req_i      in   requested PLL code
//   pll_lock_i      in   raw PLL lock (asynchronous)
//   pll_bypass_o    out  bypass control to the PLL / clock mux
//   pll_sel_o       out  applied divider select
//   pll_code_o      out  applied PLL code
//   busy_o          out  high whenever the sequencer is not idle
//   locked_o        out  PLL declared locked under the applied values
//   lock_timeout_o  out  sticky lock timeout, cleared by the next successful lock
module pll_cfg_sequencer
   import pll_pkg::*;
#(
   parameter int SWITCH_CYCLES = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int LOCK_STABLE   = 4,
   parameter int LOCK_TIMEOUT  = 4096
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              bypass_req_i,
   input  logic [SEL_W-1:0]  sel_req_i,
   input  logic [CODE_W-1:0] code_req_i,
   input  logic              pll_lock_i,
   output logic              pll_bypass_o,
   output logic [SEL_W-1:0]  pll_sel_o,
   output logic [CODE_W-1:0] pll_code_o,
   output logic              busy_o,
   output logic              locked_o,
   output logic              lock_timeout_o
);

   localparam int CNT_W    = $clog2(LOCK_TIMEOUT + 1);
   localparam int STREAK_W = $clog2(LOCK_STABLE + 1);

   localparam logic [CNT_W-1:0]    SWITCH_LAST  = CNT_W'(SWITCH_CYCLES - 1);
   localparam logic [CNT_W-1:0]    SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [STREAK_W-1:0] STABLE_LAST  = STREAK_W'(LOCK_STABLE - 1);

   pll_seq_state_e      state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [STREAK_W-1:0] streak, streak_n;
   logic                bypass, bypass_n;
   logic [SEL_W-1:0]    sel, sel_n;
   logic [CODE_W-1:0]   code, code_n;
   logic                locked, locked_n;
   logic                timeout, timeout_n;
   logic                lock_sync;
   logic                change_req;

   pll_lock_sync u_lock_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .async_i(pll_lock_i),
      .sync_o (lock_sync)
   );

   assign change_req = ({sel_req_i, code_req_i} != {sel, code});

   // Register stage. Reset lands in SETTLE so the boot lock sequence runs with code 0.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= ST_SETTLE;
         cnt     <= '0;
         streak  <= '0;
         bypass  <= 1'b1;
         sel     <= '0;
         code    <= '0;
         locked  <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         streak  <= streak_n;
         bypass  <= bypass_n;
         sel     <= sel_n;
         code    <= code_n;
         locked  <= locked_n;
         timeout <= timeout_n;
      end
   end

   // Next-state logic. The shared counter counts up in every busy state and is cleared
   // on every transition, so each wait ends when cnt reaches its "last" value.
   // The lock streak only lives in WAIT_LOCK; anywhere else it is held at zero.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CNT_W'(1);
      streak_n  = '0;
      bypass_n  = bypass;
      sel_n     = sel;
      code_n    = code;
      locked_n  = locked;
      timeout_n = timeout;

      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            // Losing lock under the applied values takes priority: fall back to bypass and relock.
            if (locked && !lock_sync) begin
               locked_n = 1'b0;
               bypass_n = 1'b1;
               state_n  = ST_WAIT_LOCK;
            end else if (change_req) begin
               if (bypass) begin
                  // Already on the bypass clock, so the mux switch wait is unnecessary.
                  sel_n    = sel_req_i;
                  code_n   = code_req_i;
                  locked_n = 1'b0;
                  state_n  = ST_SETTLE;
               end else begin
                  bypass_n = 1'b1;
                  state_n  = ST_BYP_ENTER;
               end
            end else if (bypass_req_i) begin
               bypass_n = 1'b1;
            end else if (bypass && locked) begin
               bypass_n = 1'b0;
               state_n  = ST_BYP_EXIT;
            end
         end

         ST_BYP_ENTER: begin
            if (cnt == SWITCH_LAST) begin
               sel_n    = sel_req_i;
               code_n   = code_req_i;
               locked_n = 1'b0;
               cnt_n    = '0;
               state_n  = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               cnt_n   = '0;
               state_n = ST_WAIT_LOCK;
            end
         end

         ST_WAIT_LOCK: begin
            streak_n = lock_sync ? streak + STREAK_W'(1) : '0;
            // A successful lock wins over a timeout landing in the same cycle.
            if (lock_sync && (streak == STABLE_LAST)) begin
               locked_n  = 1'b1;
               timeout_n = 1'b0;
               streak_n  = '0;
               cnt_n     = '0;
               if (!bypass_req_i) begin
                  bypass_n = 1'b0;
                  state_n  = ST_BYP_EXIT;
               end else begin
                  state_n  = ST_IDLE;
               end
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_n = 1'b1;
               streak_n  = '0;
               cnt_n     = '0;
               state_n   = ST_IDLE;
            end
         end

         ST_BYP_EXIT: begin
            if (cnt == SWITCH_LAST) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
            end
         end

         default: begin
            cnt_n   = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   assign pll_bypass_o   = bypass;
   assign pll_sel_o      = sel;
   assign pll_code_o     = code;
   assign busy_o         = (state != ST_IDLE);
   assign locked_o       = locked;
   assign lock_timeout_o = timeout;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// tb_pll_cfg_sequencer
// Directed bench for pll_cfg_sequencer: boot, code change, software bypass, glitchy lock,
// mid-sequence request, lock loss with timeout and recovery, and asynchronous reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pll_cfg_sequencer;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        bypass_req_i = 1'b0;
   logic [2:0]  sel_req_i = '0;
   logic [11:0] code_req_i = '0;
   logic        pll_lock_i = 1'b0;
   logic        pll_bypass_o;
   logic [2:0]  pll_sel_o;
   logic [11:0] pll_code_o;
   logic        busy_o;
   logic        locked_o;
   logic        lock_timeout_o;

   int checks = 0;
   int failures = 0;

   pll_cfg_sequencer dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .bypass_req_i  (bypass_req_i),
      .sel_req_i     (sel_req_i),
      .code_req_i    (code_req_i),
      .pll_lock_i    (pll_lock_i),
      .pll_bypass_o  (pll_bypass_o),
      .pll_sel_o     (pll_sel_o),
      .pll_code_o    (pll_code_o),
      .busy_o        (busy_o),
      .locked_o      (locked_o),
      .lock_timeout_o(lock_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Waits for locked_o, flagging any cycle where bypass was released before lock.
   task automatic waitLocked(input int limit, output int cycles, output logic early_release);
      cycles = 0;
      early_release = 1'b0;
      while (cycles < limit && locked_o !== 1'b1) begin
         @(negedge clk_i);
         cycles++;
         if (locked_o !== 1'b1 && pll_bypass_o !== 1'b1) early_release = 1'b1;
      end
   endtask

   task automatic waitIdle(input int limit, output int cycles);
      cycles = 0;
      while (cycles < limit && busy_o !== 1'b0) begin
         @(negedge clk_i);
         cycles++;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_bypass"},  pll_bypass_o,   1);
      checkOutput({tag, "_sel"},     pll_sel_o,      0);
      checkOutput({tag, "_code"},    pll_code_o,     0);
      checkOutput({tag, "_busy"},    busy_o,         1);
      checkOutput({tag, "_locked"},  locked_o,       0);
      checkOutput({tag, "_timeout"}, lock_timeout_o, 0);
   endtask

   initial begin
      int   cycles;
      int   boot_cycle;
      logic early;
      logic pat [8];

      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset values
      step(3);
      checkResetValues("reset");
      rstn_i = 1'b1;

      // Boot: lock rises after 10 cycles, boot sequence locks and leaves bypass
      $display("[TB] boot sequence");
      boot_cycle = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk_i);
         if (i == 10) pll_lock_i = 1'b1;
         if (locked_o === 1'b1) begin
            boot_cycle = i;
            break;
         end
      end
      checkOutput("boot_locked", locked_o, 1);
      checkOutput("boot_lock_cycle_window", (boot_cycle >= 18 && boot_cycle <= 24), 1);
      checkOutput("boot_bypass_released", pll_bypass_o, 0);
      step(7);
      checkOutput("boot_busy_during_exit", busy_o, 1);
      step(1);
      checkOutput("boot_idle", busy_o, 0);

      // Code change 0 -> 0x1A5; the PLL drops lock while the new code is applied
      $display("[TB] code change");
      code_req_i = 12'h1A5;
      pll_lock_i = 1'b0;
      step(1);
      checkOutput("chg_bypass_next_cycle", pll_bypass_o, 1);
      checkOutput("chg_busy", busy_o, 1);
      step(7);
      checkOutput("chg_code_held", pll_code_o, 12'h000);
      step(1);
      checkOutput("chg_code_applied", pll_code_o, 12'h1A5);
      checkOutput("chg_locked_cleared", locked_o, 0);
      step(20);
      pll_lock_i = 1'b1;
      waitLocked(40, cycles, early);
      checkOutput("chg_relocked", locked_o, 1);
      checkOutput("chg_no_early_release", early, 0);
      checkOutput("chg_bypass_released", pll_bypass_o, 0);
      step(7);
      checkOutput("chg_busy_during_exit", busy_o, 1);
      step(1);
      checkOutput("chg_idle", busy_o, 0);

      // Software bypass request and release while locked
      $display("[TB] software bypass");
      bypass_req_i = 1'b1;
      step(1);
      checkOutput("swbyp_bypass", pll_bypass_o, 1);
      checkOutput("swbyp_stays_idle", busy_o, 0);
      bypass_req_i = 1'b0;
      step(1);
      checkOutput("swbyp_release", pll_bypass_o, 0);
      checkOutput("swbyp_exit_busy", busy_o, 1);
      waitIdle(20, cycles);
      checkOutput("swbyp_idle", busy_o, 0);

      // Glitchy lock: 1,1,1,0,1,1,1,1 seen during WAIT_LOCK
      $display("[TB] glitchy lock");
      sel_req_i = 3'd2;
      pll_lock_i = 1'b0;
      step(30);
      checkOutput("glitch_waiting", busy_o, 1);
      checkOutput("glitch_not_locked", locked_o, 0);
      for (int k = 0; k < 8; k++) begin
         pll_lock_i = pat[k];
         step(1);
         checkOutput($sformatf("glitch_no_early_lock_%0d", k), locked_o, 0);
      end
      step(1);
      checkOutput("glitch_still_unlocked", locked_o, 0);
      step(1);
      checkOutput("glitch_locked_after_run", locked_o, 1);
      checkOutput("glitch_sel", pll_sel_o, 3'd2);
      waitIdle(20, cycles);
      checkOutput("glitch_idle", busy_o, 0);

      // Mid-sequence request: sel changes during SETTLE, a second sequence follows
      $display("[TB] mid-sequence request");
      sel_req_i = 3'd3;
      step(9);
      checkOutput("mid_first_sel", pll_sel_o, 3'd3);
      step(4);
      checkOutput("mid_in_settle_busy", busy_o, 1);
      sel_req_i = 3'd5;
      cycles = 0;
      while (cycles < 200 && !(busy_o === 1'b0 && pll_sel_o === 3'd5)) begin
         @(negedge clk_i);
         cycles++;
      end
      checkOutput("mid_final_sel", pll_sel_o, 3'd5);
      checkOutput("mid_final_idle", busy_o, 0);
      checkOutput("mid_final_locked", locked_o, 1);
      checkOutput("mid_final_bypass", pll_bypass_o, 0);

      // Lock loss in IDLE, then timeout because lock never returns
      $display("[TB] lock loss and timeout");
      pll_lock_i = 1'b0;
      cycles = 0;
      while (cycles < 6 && locked_o !== 1'b0) begin
         @(negedge clk_i);
         cycles++;
      end
      checkOutput("loss_latency", (cycles >= 1 && cycles <= 3), 1);
      checkOutput("loss_bypass", pll_bypass_o, 1);
      checkOutput("loss_busy", busy_o, 1);
      cycles = 0;
      while (cycles < 5000 && lock_timeout_o !== 1'b1) begin
         @(negedge clk_i);
         cycles++;
      end
      checkOutput("timeout_flag", lock_timeout_o, 1);
      checkOutput("timeout_cycle_window", (cycles >= 4090 && cycles <= 4100), 1);
      checkOutput("timeout_bypass", pll_bypass_o, 1);
      checkOutput("timeout_idle", busy_o, 0);
      checkOutput("timeout_unlocked", locked_o, 0);
      step(5);
      checkOutput("timeout_stays_bypassed", pll_bypass_o, 1);
      checkOutput("timeout_sticky", lock_timeout_o, 1);

      // Recovery: new code while already bypassed goes straight to SETTLE
      $display("[TB] recovery after timeout");
      code_req_i = 12'h2B6;
      pll_lock_i = 1'b1;
      step(1);
      checkOutput("recov_code_direct", pll_code_o, 12'h2B6);
      checkOutput("recov_busy", busy_o, 1);
      checkOutput("recov_flag_kept", lock_timeout_o, 1);
      waitLocked(60, cycles, early);
      checkOutput("recov_locked", locked_o, 1);
      checkOutput("recov_flag_cleared", lock_timeout_o, 0);
      checkOutput("recov_bypass_released", pll_bypass_o, 0);
      waitIdle(20, cycles);
      checkOutput("recov_idle", busy_o, 0);

      // Asynchronous reset during WAIT_LOCK
      $display("[TB] async reset mid-sequence");
      sel_req_i = 3'd1;
      pll_lock_i = 1'b0;
      step(30);
      checkOutput("rst_pre_busy", busy_o, 1);
      checkOutput("rst_pre_sel", pll_sel_o, 3'd1);
      #2 rstn_i = 1'b0;
      #1;
      checkResetValues("async_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
